// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single fixed-latency memory port.
// Each access runs IDLE -> ACCESS -> WAIT -> RESP. Request fields are latched
// at grant, so the memory side never sees the requester combinationally.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration on contention;
// when it is undefined, m0 has fixed priority.
// MEM_LAT must be in 1..15 because the latency counter is 4 bits wide.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_t;

    localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;   // 0 = m0, 1 = m1
    logic          last_q, last_d;     // master granted most recently
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          pick;

    // Arbitration: choose which master wins when leaving IDLE.
    always_comb begin
        pick = ~m0_req;
`ifdef MEM_ARB_RR_EN
        if (m0_req && m1_req) begin
            pick = ~last_q;
        end
`endif
    end

    // Next-state logic: sequence one access and capture read data at the end of WAIT.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = pick;
                    last_d  = pick;
                    we_d    = pick ? m1_we    : m0_we;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                cnt_d   = LatInit;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 4'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decoded from state and latched fields only.
    always_comb begin
        busy      = (state_q != StIdle);
        m0_gnt    = busy && !owner_q;
        m1_gnt    = busy && owner_q;
        m0_ack    = (state_q == StResp) && !owner_q;
        m1_ack    = (state_q == StResp) && owner_q;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        mem_en    = (state_q == StAccess);
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// dut1 runs at MEM_LAT=1, dut3 at MEM_LAT=3; both share clock and reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic        b_m0_gnt, b_m0_ack, b_m1_gnt, b_m1_ack;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the dut1 control outputs: {busy, m0_gnt, m1_gnt, m0_ack, m1_ack, mem_en, mem_we}.
    function automatic logic [31:0] ctl1();
        return {25'd0, busy, m0_gnt, m1_gnt, m0_ack, m1_ack, mem_en, mem_we};
    endfunction

    initial begin
        logic [1:0] exp_gnt [3];
        rst = 1'b1;
        {m0_req, m0_we, m1_req, m1_we} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
        {b_m0_req, b_m0_we, b_m1_req, b_m1_we} = '0;
        {b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata, b_mem_rdata} = '0;

        // Reset state
        tick();
        tick();
        check("rst_ctl", ctl1(), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_rdata0", m0_rdata, 32'h0);
        check("rst_rdata1", m1_rdata, 32'h0);
        rst = 1'b0;
        tick();
        check("idle_ctl", ctl1(), 32'h0);

        // Single read by m0, MEM_LAT=1
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        tick();
        check("rd_access_ctl", ctl1(), 32'b1100010);
        check("rd_access_addr", mem_addr, 32'h10);
        mem_rdata = 32'hDEADBEEF;
        tick();
        check("rd_wait_ctl", ctl1(), 32'b1100000);
        tick();
        check("rd_resp_ctl", ctl1(), 32'b1101000);
        check("rd_resp_data", m0_rdata, 32'hDEADBEEF);
        tick();
        m0_req = 1'b0;
        check("rd_idle_ctl", ctl1(), 32'h0);
        tick();

        // Write by m1
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        tick();
        check("wr_access_ctl", ctl1(), 32'b1010011);
        check("wr_addr", mem_addr, 32'h20);
        check("wr_wdata", mem_wdata, 32'h12345678);
        mem_rdata = 32'hBAD0BAD0;
        tick();
        check("wr_wait_ctl", ctl1(), 32'b1010000);
        tick();
        check("wr_resp_ctl", ctl1(), 32'b1010100);
        check("wr_rdata1_kept", m1_rdata, 32'h0);
        check("wr_rdata0_kept", m0_rdata, 32'hDEADBEEF);
        tick();
        m1_req = 1'b0; m1_we = 1'b0;
        tick();

        // Contention, both persistent; last grant so far went to m1
`ifdef MEM_ARB_RR_EN
        exp_gnt = '{2'b10, 2'b01, 2'b10};
`else
        exp_gnt = '{2'b10, 2'b10, 2'b10};
`endif
        m0_req = 1'b1; m0_addr = 32'h30; m1_req = 1'b1; m1_addr = 32'h34;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("arb_gnt%0d", k), {30'd0, m0_gnt, m1_gnt}, {30'd0, exp_gnt[k]});
            check($sformatf("arb_addr%0d", k), mem_addr, exp_gnt[k][1] ? 32'h30 : 32'h34);
            tick();
            tick();
            check($sformatf("arb_ack%0d", k), {30'd0, m0_ack, m1_ack}, {30'd0, exp_gnt[k]});
            tick();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // Request fields changing after grant
        m0_req = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h0;
        tick();
        check("chg_access_addr", mem_addr, 32'h10);
        m0_addr = 32'h99; m0_wdata = 32'hFFFFFFFF;
        tick();
        check("chg_wait_addr", mem_addr, 32'h10);
        check("chg_wait_wdata", mem_wdata, 32'h0);
        tick();
        check("chg_resp_ctl", ctl1(), 32'b1101000);
        tick();
        m0_req = 1'b0;
        tick();

        // Reset asserted during WAIT
        m0_req = 1'b1; m0_addr = 32'h50;
        tick();
        tick();
        check("mid_wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        check("mid_rst_ctl", ctl1(), 32'h0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_rdata0", m0_rdata, 32'h0);
        tick();
        tick();
        check("mid_rst_hold", ctl1(), 32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_noack", ctl1(), 32'h0);
        tick();
        check("post_rst_noack2", ctl1(), 32'h0);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h60;
        tick();
        check("post_access_ctl", ctl1(), 32'b1010010);
        check("post_access_addr", mem_addr, 32'h60);
        mem_rdata = 32'hCAFEF00D;
        tick();
        tick();
        check("post_resp_ctl", ctl1(), 32'b1010100);
        check("post_rdata1", m1_rdata, 32'hCAFEF00D);
        check("post_rdata0", m0_rdata, 32'h0);
        tick();
        m1_req = 1'b0;
        tick();

        // MEM_LAT=3 read on dut3: data valid 3 cycles after mem_en
        b_m0_req = 1'b1; b_m0_addr = 32'h40;
        tick();
        check("lat3_en", 32'(b_mem_en), 32'h1);
        check("lat3_addr", b_mem_addr, 32'h40);
        b_mem_rdata = 32'h11111111;
        tick();
        check("lat3_ack_t2", 32'(b_m0_ack), 32'h0);
        b_mem_rdata = 32'h22222222;
        tick();
        check("lat3_ack_t3", 32'(b_m0_ack), 32'h0);
        b_mem_rdata = 32'h33333333;
        tick();
        check("lat3_ack_t4", 32'(b_m0_ack), 32'h0);
        check("lat3_busy_t4", 32'(b_busy), 32'h1);
        b_mem_rdata = 32'h44444444;
        tick();
        check("lat3_ack_t5", 32'(b_m0_ack), 32'h1);
        check("lat3_rdata", b_m0_rdata, 32'h33333333 + 32'h11111111);
        b_mem_rdata = 32'h55555555;
        tick();
        b_m0_req = 1'b0;
        check("lat3_idle", {30'd0, b_busy, b_m0_ack}, 32'h0);
        check("lat3_rdata_hold", b_m0_rdata, 32'h44444444);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single unified instruction/data memory port between two masters.
- Master 0 is the multicycle CPU, on the memory-address/write-enable path driven by the control FSM. Master 1 is a secondary requester (bootloader/DMA).
- Sequences each access through a fixed-latency memory, then returns read data with a one-cycle ack.
- Sits between the core/loader and the memory macro. The CPU stalls its FSM until m0_ack.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
m0_req  in  1  CPU request; held until m0_ack
m0_we  in  1  CPU write enable (1=write, 0=read)
m0_addr  in  AW  CPU address
m0_wdata  in  DW  CPU write data
m0_gnt  out  1  CPU owns the memory (level)
m0_ack  out  1  CPU access complete (1-cycle pulse)
m0_rdata  out  DW  CPU read data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as m0_* for master 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in any state except IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE; all outputs 0; rdata registers 0; latched request fields 0; owner=m0; last_grant=m1.
  - An in-flight access is abandoned with no ack.
- FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
- IDLE:
  - Sample m0_req/m1_req.
  - If either is set: pick the owner, latch its we/addr/wdata into registers, set the owner's gnt, go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched registers (never combinationally from the requester).
  - Load the latency counter with MEM_LAT-1. Go to WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en=0; mem_addr/mem_wdata keep the latched values.
  - Decrement the counter each cycle. When the counter reaches 0: capture mem_rdata into the owner's rdata register if it is a read, then go to RESP.
- RESP (1 cycle):
  - Owner's ack=1 with its rdata stable. Go to IDLE.
  - gnt drops on entry to IDLE.
- Latency: req high in IDLE cycle T -> ack in cycle T+2+MEM_LAT (T+3 at default). Minimum spacing between accesses is 3+MEM_LAT cycles.
- Writes:
  - ack is pulsed identically to reads.
  - The rdata register keeps its previous value.
- rdata of the non-owner never changes.
- Requests are sampled only in IDLE. A requester wanting no further access deasserts req in the cycle after ack; req still high in IDLE starts a new access.
- Dropping req before ack is a protocol violation. The access still completes and ack is still pulsed.
- Requester fields changing after grant have no effect (already latched).
- Arbitration (default): fixed priority, m0 wins when both request. last_grant is updated on every grant.
- At most one gnt and one ack are high in any cycle. gnt and ack never go to the non-owner.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. When both request in IDLE, grant the master not equal to last_grant; a single requester is always granted. Neither master can be starved for more than one access.
- Undefined: fixed m0 priority as above. last_grant is still maintained but does not affect the choice.

Test Plan:
- Single read, MEM_LAT=1:
  - Stimulus: m0_req=1, m0_we=0, addr=0x10 in cycle T; memory returns 0xDEADBEEF.
  - Response: mem_en=1 with mem_addr=0x10 at T+1; m0_ack and m0_rdata=0xDEADBEEF at T+3; busy high T+1..T+3.
- Write:
  - Stimulus: m1 write, addr=0x20, wdata=0x12345678.
  - Response: single mem_en/mem_we pulse with those values; m1_ack 3 cycles later; m1_rdata unchanged.
- Simultaneous requests, both persistent, 3 accesses:
  - Without MEM_ARB_RR_EN: grant order m0, m0, m0.
  - With MEM_ARB_RR_EN: grant order m0, m1, m0.
- MEM_LAT=3:
  - Stimulus: read of 0x40.
  - Response: ack exactly 5 cycles after req sampled; rdata equals mem_rdata from 3 cycles after mem_en.
- Reset mid-operation:
  - Stimulus: assert rst during WAIT.
  - Response: immediately all outputs 0, busy=0, no ack ever pulses; a new m1 request after reset completes normally.
- Request-field change after grant:
  - Stimulus: change m0_addr from 0x10 to 0x99 in ACCESS.
  - Response: mem_addr stays 0x10 through WAIT.
